// File: rtl/keypad_emulator.sv
// keypad_emulator: responder model of a 4x4 matrix keypad.
// Closes one contact per request, with optional deterministic bounce.
module keypad_emulator #(
  parameter int HOLD_CYCLES   = 2000000,
  parameter int GAP_CYCLES    = 1000000,
  parameter int BOUNCE_COUNT  = 0,
  parameter int BOUNCE_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  input  logic [3:0] key_row,
  output logic [3:0] key_col,
  output logic       pressed,
  output logic       busy,
  output logic       done,
  output logic       multi_row
);

  localparam int MAX_HG =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXC =
    (MAX_HG > BOUNCE_PERIOD) ? MAX_HG : BOUNCE_PERIOD;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int PW =
    (BOUNCE_COUNT > 0) ? $clog2(BOUNCE_COUNT + 1) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] PER_LD  =
    CW'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
  localparam logic [PW-1:0] PH_LAST =
    PW'((BOUNCE_COUNT > 0) ? BOUNCE_COUNT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BOUNCE,
    S_HOLD,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    key_q, key_d;
  logic          contact_q, contact_d;
  logic          done_q, done_d;
  logic          multi_q, multi_d;
  logic          multi_hit;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    key_d     = key_q;
    contact_d = contact_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          key_d     = req_key;
          contact_d = 1'b1;
          phase_d   = '0;
          if (BOUNCE_COUNT > 0) begin
            state_d = S_BOUNCE;
            cnt_d   = PER_LD;
          end else begin
            state_d = S_HOLD;
            cnt_d   = HOLD_LD;
          end
        end
      end
      S_BOUNCE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (phase_q == PH_LAST) begin
          state_d   = S_HOLD;
          cnt_d     = HOLD_LD;
          contact_d = 1'b1;
        end else begin
          // next phase is even (closed) when the current one is odd
          phase_d   = phase_q + 1'b1;
          cnt_d     = PER_LD;
          contact_d = phase_q[0];
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d   = S_GAP;
          cnt_d     = GAP_LD;
          contact_d = 1'b0;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  assign done_d    = (state_q == S_GAP) && (cnt_q == '0);
  assign multi_hit = contact_q && ($countones(~key_row) >= 2);
  assign multi_d   = multi_q | multi_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      key_q     <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      multi_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      key_q     <= key_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      multi_q   <= multi_d;
    end
  end

  assign key_col = (contact_q && !key_row[key_q[3:2]])
                 ? ~(4'b0001 << key_q[1:0])
                 : 4'b1111;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign pressed   = contact_q;
  assign done      = done_q;
  assign multi_row = multi_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of keypad_emulator.
// dut0 = clean press (8/4), dut1 = bounced press (3x2, hold 4, gap 2).
module tb_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [3:0] k0 = 4'h0, k1 = 4'h0;
  logic [3:0] row0 = 4'hF, row1 = 4'hF;
  logic       rdy0, rdy1, pr0, pr1, bz0, bz1;
  logic       dn0, dn1, mr0, mr1;
  logic [3:0] col0, col1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES(8), .GAP_CYCLES(4),
    .BOUNCE_COUNT(0), .BOUNCE_PERIOD(1)
  ) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(v0), .req_key(k0), .req_ready(rdy0),
    .key_row(row0), .key_col(col0), .pressed(pr0),
    .busy(bz0), .done(dn0), .multi_row(mr0)
  );

  keypad_emulator #(
    .HOLD_CYCLES(4), .GAP_CYCLES(2),
    .BOUNCE_COUNT(3), .BOUNCE_PERIOD(2)
  ) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(v1), .req_key(k1), .req_ready(rdy1),
    .key_row(row1), .key_col(col1), .pressed(pr1),
    .busy(bz1), .done(dn1), .multi_row(mr1)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v0 = 1'b1; k0 = 4'h6; row0 = 4'b1101;
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++;
    if ({col0, pr0, bz0, rdy0, dn0, mr0} !== 9'b1111_0_0_1_0_0) begin
      errors++;
      $display("FAIL reset0 got=%b want=111100100",
               {col0, pr0, bz0, rdy0, dn0, mr0});
    end
    checks++;
    if ({col1, pr1, bz1, rdy1, dn1, mr1} !== 9'b1111_0_0_1_0_0) begin
      errors++;
      $display("FAIL reset1 got=%b want=111100100",
               {col1, pr1, bz1, rdy1, dn1, mr1});
    end
    @(posedge clk); #1;
    reset = 1'b0; v0 = 1'b0; row0 = 4'hF;
    next_cycle();
  endtask

  task automatic test_clean_press();
    logic       ep, ed, eb;
    logic [3:0] ec;
    for (int k = 0; k <= 15; k++) begin
      v0 = (k == 0); k0 = 4'h6; row0 = 4'b1101;
      @(negedge clk);
      ep = (k >= 1) && (k <= 8);
      ed = (k == 13);
      eb = (k >= 1) && (k <= 12);
      ec = ep ? 4'b1011 : 4'b1111;
      checks++;
      if ({pr0, dn0, bz0, rdy0} !== {ep, ed, eb, ~eb}) begin
        errors++;
        $display("FAIL clean_ctl k=%0d got=%b want=%b",
                 k, {pr0, dn0, bz0, rdy0}, {ep, ed, eb, ~eb});
      end
      checks++;
      if (col0 !== ec) begin
        errors++;
        $display("FAIL clean_col k=%0d got=%b want=%b", k, col0, ec);
      end
      row0 = 4'b1110;
      #1;
      checks++;
      if (col0 !== 4'b1111) begin
        errors++;
        $display("FAIL clean_other_row k=%0d got=%b want=1111",
                 k, col0);
      end
      row0 = 4'b1101;
      next_cycle();
    end
  endtask

  task automatic test_bounce();
    logic [10:0] pat;
    logic        ep, ed;
    logic [3:0]  ec;
    pat = 11'b0_1111_11_00_11;
    for (int k = 0; k <= 14; k++) begin
      v1 = (k == 0); k1 = 4'hF; row1 = 4'b0111;
      @(negedge clk);
      ep = (k >= 1 && k <= 10) ? pat[k-1] : 1'b0;
      ed = (k == 13);
      ec = ep ? 4'b0111 : 4'b1111;
      checks++;
      if ({pr1, col1, dn1} !== {ep, ec, ed}) begin
        errors++;
        $display("FAIL bounce k=%0d got=%b want=%b",
                 k, {pr1, col1, dn1}, {ep, ec, ed});
      end
      next_cycle();
    end
    row1 = 4'hF;
  endtask

  task automatic test_back_to_back();
    logic       ep, er, ed;
    logic [3:0] ec;
    for (int k = 0; k <= 26; k++) begin
      v0 = (k <= 13);
      k0 = (k == 0) ? 4'h0 : 4'h9;
      row0 = (k < 13) ? 4'b1110 : 4'b1011;
      @(negedge clk);
      ep = (k >= 1 && k <= 8) || (k >= 14 && k <= 21);
      er = (k == 0) || (k == 13) || (k == 26);
      ed = (k == 13) || (k == 26);
      if (k >= 1 && k <= 8) ec = 4'b1110;
      else if (k >= 14 && k <= 21) ec = 4'b1101;
      else ec = 4'b1111;
      checks++;
      if ({rdy0, pr0, dn0, col0} !== {er, ep, ed, ec}) begin
        errors++;
        $display("FAIL b2b k=%0d got=%b want=%b",
                 k, {rdy0, pr0, dn0, col0}, {er, ep, ed, ec});
      end
      next_cycle();
    end
    v0 = 1'b0; row0 = 4'hF;
  endtask

  task automatic test_sweep();
    logic [3:0] rows [4];
    logic [3:0] ec;
    rows[0] = 4'b1110; rows[1] = 4'b1101;
    rows[2] = 4'b1011; rows[3] = 4'b0111;
    for (int k = 0; k <= 13; k++) begin
      v0 = (k == 0); k0 = 4'hA;
      row0 = rows[k % 4];
      @(negedge clk);
      ec = (k >= 1 && k <= 8 && row0 == 4'b1011) ? 4'b1011 : 4'b1111;
      checks++;
      if (col0 !== ec) begin
        errors++;
        $display("FAIL sweep k=%0d row=%b got=%b want=%b",
                 k, row0, col0, ec);
      end
      if (k == 13) begin
        checks++;
        if (dn0 !== 1'b1) begin
          errors++;
          $display("FAIL sweep_done got=%b want=1", dn0);
        end
      end
      next_cycle();
    end
    row0 = 4'hF;
  endtask

  task automatic test_multi_row();
    logic em;
    for (int k = 0; k < 3; k++) begin
      row0 = 4'b1100;
      @(negedge clk);
      checks++;
      if (mr0 !== 1'b0) begin
        errors++;
        $display("FAIL multi_idle k=%0d got=%b want=0", k, mr0);
      end
      next_cycle();
    end
    for (int k = 0; k <= 14; k++) begin
      v0 = (k == 0); k0 = 4'h0;
      row0 = (k == 2) ? 4'b1100 : 4'b1110;
      @(negedge clk);
      em = (k >= 3);
      checks++;
      if (mr0 !== em) begin
        errors++;
        $display("FAIL multi k=%0d got=%b want=%b", k, mr0, em);
      end
      next_cycle();
    end
    row0 = 4'hF;
  endtask

  task automatic test_reset_mid_hold();
    logic eb, ed;
    for (int k = 0; k <= 17; k++) begin
      reset = (k == 3);
      v0 = (k == 0) || (k == 3) || (k == 4);
      k0 = 4'h6;
      row0 = (k == 2) ? 4'b1100 : 4'b1101;
      @(negedge clk);
      if (k == 4) begin
        checks++;
        if ({pr0, col0, bz0, rdy0, dn0, mr0} !== 9'b0_1111_0_1_0_0) begin
          errors++;
          $display("FAIL rst_mid got=%b want=011110100",
                   {pr0, col0, bz0, rdy0, dn0, mr0});
        end
      end else if (k >= 5) begin
        eb = (k <= 16);
        ed = (k == 17);
        checks++;
        if ({bz0, pr0 && (k <= 12), dn0} !== {eb, (k <= 12), ed}) begin
          errors++;
          $display("FAIL rst_after k=%0d got=%b want=%b",
                   k, {bz0, pr0, dn0}, {eb, (k <= 12), ed});
        end
      end else if (k == 3) begin
        checks++;
        if ({pr0, mr0} !== 2'b11) begin
          errors++;
          $display("FAIL rst_pre got=%b want=11", {pr0, mr0});
        end
      end
      next_cycle();
    end
    reset = 1'b0; v0 = 1'b0; row0 = 4'hF;
  endtask

  initial begin
    next_cycle();
    test_reset();
    test_clean_press();
    test_bounce();
    test_back_to_back();
    test_sweep();
    test_multi_row();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Responder side of the 4x4 matrix keypad interface. It models a physical keypad on the row/column lines that the keypad scanner drives and samples. It accepts key-press requests through a valid/ready handshake. For each request it closes the selected contact for a programmable time, with optional deterministic contact bounce, and then releases it. It is used in place of the real keypad in system benches and for hardware self-test of the game top.

## Interface
Parameters:
- HOLD_CYCLES, 2000000: cycles the contact stays closed after bounce ends (must be ≥1).
- GAP_CYCLES, 1000000: cycles of guaranteed release after the hold, before the next request is accepted (must be ≥1).
- BOUNCE_COUNT, 0: number of bounce phases before the stable hold (0 = clean press).
- BOUNCE_PERIOD, 1000: cycles per bounce phase (must be ≥1 if BOUNCE_COUNT>0).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  press request present.
- req_key  in  4  key index; row = req_key[3:2], column = req_key[1:0].
- req_ready  out  1  high only in IDLE.
- key_row  in  4  row drive from scanner, active-low; bit r low = row r selected.
- key_col  out  4  column return, active-low; idle 4'b1111 (pull-up model).
- pressed  out  1  registered contact state (1 = closed).
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a press/release sequence completes.
- multi_row  out  1  sticky flag: more than one key_row bit was low while the contact was closed.

## Operation
- Request is captured as key_q, with row index r = key_q[3:2] and column index c = key_q[1:0].
- States: IDLE, BOUNCE, HOLD, GAP.
- IDLE:
  - req_ready=1, contact=0.
  - On req_valid && req_ready: latch req_key into key_q and load the counter.
  - Next state is BOUNCE if BOUNCE_COUNT>0, otherwise HOLD.
- BOUNCE:
  - Runs BOUNCE_COUNT phases of BOUNCE_PERIOD cycles each.
  - Contact = 1 in even phases (0, 2, …) and 0 in odd phases.
  - After the last phase, next state is HOLD.
- HOLD: contact=1 for exactly HOLD_CYCLES cycles, then GAP.
- GAP: contact=0 for exactly GAP_CYCLES cycles, then IDLE. done=1 in the first IDLE cycle only.
- key_col is combinational from key_row and the registered contact/key_q:
  - key_col = ~(4'b0001 << c) when contact=1 and key_row[r]=0.
  - Otherwise key_col = 4'b1111.
  - key_row bits other than r do not affect key_col.
- multi_row:
  - Set in any cycle where contact=1 and two or more key_row bits are 0.
  - Cleared only by reset.
- Requests while busy are not accepted (req_ready=0). req_key changes while busy have no effect.
- Counters are sized by $clog2 of the largest of HOLD_CYCLES, GAP_CYCLES and BOUNCE_PERIOD. Phase counter width is $clog2(BOUNCE_COUNT+1). No wrap is permitted; each counter reloads at every state entry.

## Timing
- Reset values:
  - State IDLE, contact 0, key_q 0, done 0, multi_row 0.
  - Outputs: key_col 4'b1111, pressed 0, busy 0, req_ready 1.
- Accept in cycle t (handshake sampled at edge t). Then:
  - pressed=1 and busy=1 from cycle t+1 (clean press).
  - Total closed duration is exactly HOLD_CYCLES cycles in the clean case.
- The first release cycle is t+1+BOUNCE_COUNT·BOUNCE_PERIOD+HOLD_CYCLES.
- done pulses at t+1+BOUNCE_COUNT·BOUNCE_PERIOD+HOLD_CYCLES+GAP_CYCLES. In that cycle req_ready=1, so back-to-back requests are accepted with no idle cycle.
- key_col responds to key_row in the same cycle (zero latency, combinational path).
- Reset asserted mid-sequence:
  - Next cycle: IDLE, pressed=0, key_col=4'b1111.
  - No done pulse.
  - multi_row cleared.
- Reset and req_valid in the same cycle: reset wins; the request is dropped.

## Test plan
- Clean press (HOLD_CYCLES=8, GAP_CYCLES=4, BOUNCE_COUNT=0), req_key=4'h6 accepted at cycle 10:
  - pressed=1 for cycles 11–18.
  - With key_row=4'b1101, key_col=4'b1011 during 11–18 and 4'b1111 otherwise.
  - With key_row=4'b1110 throughout, key_col=4'b1111 throughout.
  - done=1 at cycle 23 only.
- Bounce (BOUNCE_COUNT=3, BOUNCE_PERIOD=2, HOLD_CYCLES=4), key 4'hF, key_row=4'b0111, accept at 0:
  - pressed pattern for cycles 1–10 is 1,1,0,0,1,1,1,1,1,1.
  - key_col=4'b0111 whenever pressed=1.
- Back-to-back: req_valid held high with keys 4'h0 then 4'h9. The second request is accepted exactly in the done cycle, and req_ready is low for all cycles in between.
- Scanner sweep: key 4'hA held while key_row rotates 1110→1101→1011→0111 each cycle. key_col=4'b1011 only when key_row=4'b1011.
- multi_row: key_row=4'b1100 while pressed → multi_row=1 next cycle and it stays 1 after done. Repeating the same condition with pressed=0 leaves the flag at 0.
- Reset mid-hold: reset at HOLD cycle 3 → next cycle pressed=0, key_col=4'b1111, busy=0, no done. A new request is accepted on the following cycle.
